// File: rtl/rx_byte_fifo.sv
// Receive byte buffer: write-strobe qualification, DEPTH-entry FIFO with registered pop
// and sticky overflow, plus a WIN-entry window of the most recent write-event bytes.
module rx_byte_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int WIN     = 3,
  parameter int EDGE_IN = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_in,
  input  logic [DATA_W-1:0]         din,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_valid,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  input  logic                      clr_ovf,
  output logic [WIN*DATA_W-1:0]     window
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_W-1:0]     dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  ovf_q, ovf_d;
  logic [WIN*DATA_W-1:0] window_q, window_d;
  logic [WIN*DATA_W-1:0] win_shift;
  logic                  wr_in_q;

  logic wr_evt, rd_ok, wr_ok, drop, is_empty, is_full;

  // Loads 1 in reset so a level held high across reset release is not seen as a rising edge.
  always_ff @(posedge clk) begin
    if (rst) wr_in_q <= 1'b1;
    else     wr_in_q <= wr_in;
  end

  assign wr_evt   = (EDGE_IN != 0) ? (wr_in & ~wr_in_q) : wr_in;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign rd_ok    = rd_en & ~is_empty;
  // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
  assign wr_ok    = wr_evt & (~is_full | rd_ok);
  assign drop     = wr_evt & is_full & ~rd_ok;

  generate
    if (WIN == 1) begin : g_win1
      assign win_shift = din;
    end else begin : g_winn
      assign win_shift = {window_q[(WIN-1)*DATA_W-1:0], din};
    end
  endgenerate

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    ovf_d        = ovf_q;
    window_d     = window_q;

    if (wr_ok) wptr_d = wptr_q + PW'(1);
    if (rd_ok) begin
      rptr_d       = rptr_q + PW'(1);
      dout_d       = mem_q[rptr_q];
      dout_valid_d = 1'b1;
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear when both happen in one cycle.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;

    if (wr_evt) window_d = win_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      window_q     <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
      window_q     <= window_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= din;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign window     = window_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo: one level-input (EDGE_IN=1) and one strobe-input
// (EDGE_IN=0) instance sharing clock and reset.
module tb_rx_byte_fifo;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int WN = 3;
  localparam int CW = $clog2(DP) + 1;

  logic clk = 1'b0;
  logic rst;

  logic          wr_e, rd_e, clr_e;
  logic [DW-1:0] din_e, dout_e;
  logic          dv_e, empty_e, full_e, ovf_e;
  logic [CW-1:0] count_e;
  logic [WN*DW-1:0] win_e;

  logic          wr_s, rd_s, clr_s;
  logic [DW-1:0] din_s, dout_s;
  logic          dv_s, empty_s, full_s, ovf_s;
  logic [CW-1:0] count_s;
  logic [WN*DW-1:0] win_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_byte_fifo #(.DATA_W(DW), .DEPTH(DP), .WIN(WN), .EDGE_IN(1)) u_edge (
    .clk(clk), .rst(rst), .wr_in(wr_e), .din(din_e), .rd_en(rd_e),
    .dout(dout_e), .dout_valid(dv_e), .empty(empty_e), .full(full_e),
    .count(count_e), .overflow(ovf_e), .clr_ovf(clr_e), .window(win_e)
  );

  rx_byte_fifo #(.DATA_W(DW), .DEPTH(DP), .WIN(WN), .EDGE_IN(0)) u_strb (
    .clk(clk), .rst(rst), .wr_in(wr_s), .din(din_s), .rd_en(rd_s),
    .dout(dout_s), .dout_valid(dv_s), .empty(empty_s), .full(full_s),
    .count(count_s), .overflow(ovf_s), .clr_ovf(clr_s), .window(win_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_e(input logic [DW-1:0] d);
    din_e = d; wr_e = 1'b1;
    tick();
    wr_e = 1'b0;
    tick();
  endtask

  task automatic pop_e(input logic [DW-1:0] exp, input string tag);
    rd_e = 1'b1;
    tick();
    rd_e = 1'b0;
    chk({tag, "_dv"}, 64'(dv_e), 64'(1));
    chk({tag, "_dout"}, 64'(dout_e), 64'(exp));
    tick();
    chk({tag, "_dv_end"}, 64'(dv_e), 64'(0));
  endtask

  task automatic push_s(input logic [DW-1:0] d);
    din_s = d; wr_s = 1'b1;
    tick();
    wr_s = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wr_e = 1'b1; rd_e = 1'b0; clr_e = 1'b0; din_e = '0;
    wr_s = 1'b0; rd_s = 1'b0; clr_s = 1'b0; din_s = '0;
    tick(); tick();
    rst = 1'b0;

    // Level held high through and after reset must not write
    repeat (10) tick();
    chk("rst_count", 64'(count_e), 64'(0));
    chk("rst_window", 64'(win_e), 64'(0));
    chk("rst_empty", 64'(empty_e), 64'(1));
    chk("rst_full", 64'(full_e), 64'(0));
    chk("rst_ovf", 64'(ovf_e), 64'(0));
    chk("rst_dv", 64'(dv_e), 64'(0));
    chk("rst_dout", 64'(dout_e), 64'(0));
    chk("rst_s_empty", 64'(empty_s), 64'(1));

    wr_e = 1'b0; tick();
    din_e = 8'hA5; wr_e = 1'b1; tick();
    chk("a5_count", 64'(count_e), 64'(1));
    chk("a5_win", 64'(win_e[7:0]), 64'(8'hA5));
    tick();
    chk("a5_level_once", 64'(count_e), 64'(1));
    wr_e = 1'b0; tick();
    pop_e(8'hA5, "pop_a5");
    chk("a5_empty", 64'(empty_e), 64'(1));

    // Four edge-qualified writes then four pops
    push_e(8'h11); push_e(8'h22); push_e(8'h33); push_e(8'h44);
    chk("w4_win", 64'(win_e), 64'(24'h223344));
    chk("w4_count", 64'(count_e), 64'(4));
    pop_e(8'h11, "pop11");
    pop_e(8'h22, "pop22");
    pop_e(8'h33, "pop33");
    pop_e(8'h44, "pop44");
    chk("w4_empty", 64'(empty_e), 64'(1));
    chk("w4_count0", 64'(count_e), 64'(0));

    // Empty pop is ignored: dout holds, no pulse
    rd_e = 1'b1; tick(); rd_e = 1'b0;
    chk("emptypop_dv", 64'(dv_e), 64'(0));
    chk("emptypop_dout", 64'(dout_e), 64'(8'h44));
    chk("emptypop_count", 64'(count_e), 64'(0));

    // Fill, then one dropped write
    for (int i = 0; i < DP; i++) push_e(8'(i));
    chk("fill_full", 64'(full_e), 64'(1));
    chk("fill_ovf0", 64'(ovf_e), 64'(0));
    push_e(8'h10);
    chk("drop_full", 64'(full_e), 64'(1));
    chk("drop_count", 64'(count_e), 64'(16));
    chk("drop_ovf", 64'(ovf_e), 64'(1));
    chk("drop_win", 64'(win_e), 64'(24'h0E0F10));
    for (int i = 0; i < DP; i++) pop_e(8'(i), $sformatf("drain%0d", i));
    chk("drain_empty", 64'(empty_e), 64'(1));
    chk("drain_ovf_sticky", 64'(ovf_e), 64'(1));
    clr_e = 1'b1; tick(); clr_e = 1'b0;
    chk("clr_ovf", 64'(ovf_e), 64'(0));

    // Strobe instance: full with simultaneous read and write
    for (int i = 0; i < DP; i++) push_s(8'(i));
    chk("s_full", 64'(full_s), 64'(1));
    chk("s_count16", 64'(count_s), 64'(16));
    din_s = 8'h77; wr_s = 1'b1; rd_s = 1'b1; tick();
    wr_s = 1'b0; rd_s = 1'b0;
    chk("s_rw_dv", 64'(dv_s), 64'(1));
    chk("s_rw_dout", 64'(dout_s), 64'(8'h00));
    chk("s_rw_count", 64'(count_s), 64'(16));
    chk("s_rw_ovf", 64'(ovf_s), 64'(0));

    // Drop and clear together: set wins
    din_s = 8'h88; wr_s = 1'b1; clr_s = 1'b1; tick();
    wr_s = 1'b0; clr_s = 1'b0;
    chk("s_setwins_ovf", 64'(ovf_s), 64'(1));
    chk("s_setwins_count", 64'(count_s), 64'(16));
    chk("s_setwins_win", 64'(win_s), 64'(24'h0F7788));
    clr_s = 1'b1; tick(); clr_s = 1'b0;
    chk("s_clr", 64'(ovf_s), 64'(0));

    // Held rd_en pops one per cycle: 01..0F then 77
    rd_s = 1'b1;
    for (int i = 1; i <= DP; i++) begin
      tick();
      chk($sformatf("s_drain%0d_dv", i), 64'(dv_s), 64'(1));
      chk($sformatf("s_drain%0d", i), 64'(dout_s), (i == DP) ? 64'h77 : 64'(i));
    end
    tick();
    rd_s = 1'b0;
    chk("s_drain_stop_dv", 64'(dv_s), 64'(0));
    chk("s_drain_empty", 64'(empty_s), 64'(1));

    // Empty with simultaneous read and write: no fall-through
    din_s = 8'h5A; wr_s = 1'b1; rd_s = 1'b1; tick();
    wr_s = 1'b0; rd_s = 1'b0;
    chk("s_e_rw_dv", 64'(dv_s), 64'(0));
    chk("s_e_rw_count", 64'(count_s), 64'(1));
    chk("s_e_rw_dout", 64'(dout_s), 64'(8'h77));
    rd_s = 1'b1; tick(); rd_s = 1'b0;
    chk("s_5a_dv", 64'(dv_s), 64'(1));
    chk("s_5a_dout", 64'(dout_s), 64'(8'h5A));

    // Reset mid-operation with a pop pending
    for (int i = 1; i <= 5; i++) push_e(8'(i));
    chk("pre_rst_count", 64'(count_e), 64'(5));
    rst = 1'b1; rd_e = 1'b1; tick();
    rst = 1'b0;
    chk("mrst_dv", 64'(dv_e), 64'(0));
    chk("mrst_count", 64'(count_e), 64'(0));
    chk("mrst_empty", 64'(empty_e), 64'(1));
    chk("mrst_window", 64'(win_e), 64'(0));
    chk("mrst_ovf", 64'(ovf_e), 64'(0));
    chk("mrst_dout", 64'(dout_e), 64'(0));
    tick();
    chk("mrst_rd_dv1", 64'(dv_e), 64'(0));
    tick();
    chk("mrst_rd_dv2", 64'(dv_e), 64'(0));
    rd_e = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
Name: rx_byte_fifo

Overview:
Parametrised receive buffer for the JTAG byte path, sitting between jtag_controller (Dout/R) and the hex display / consumer logic. It combines built-in edge detection of the receive strobe, a DEPTH-entry FIFO with a pop interface and a sticky overflow flag, and a WIN-entry "latest bytes" window for display.

Parameters:
DATA_W, 8, width of each entry in bits
DEPTH, 16, number of FIFO entries; power of 2, at least 2
WIN, 3, number of entries in the display window; 1 to DEPTH
EDGE_IN, 1, selects write qualification: 1 = wr_in is a level and writes on its rising edge; 0 = wr_in is a single-cycle strobe

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active high
wr_in  in  1  write request (level or strobe per EDGE_IN)
din  in  DATA_W  write data, sampled in the write-event cycle
rd_en  in  1  pop request
dout  out  DATA_W  popped entry, registered
dout_valid  out  1  one-cycle pulse; dout holds new data
empty  out  1  count == 0
full  out  1  count == DEPTH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky; set when a write was dropped
clr_ovf  in  1  clears overflow
window  out  WIN*DATA_W  last WIN write-event bytes; newest in [DATA_W-1:0]

Behaviour:
- Reset (rst=1 at an edge):
  - wptr, rptr, count, dout, dout_valid, overflow, window all go to 0.
  - empty=1, full=0.
  - Internal wr_in_q loads 1, so a wr_in held high through reset produces no write after release.
  - Reset mid-operation discards all contents. A dout_valid due that cycle is suppressed.
- Write event wr_evt:
  - EDGE_IN=1: wr_evt = wr_in & ~wr_in_q, where wr_in_q <= wr_in each cycle (1 during reset).
  - EDGE_IN=0: wr_evt = wr_in.
- FIFO write: on wr_evt with a slot available, mem[wptr] <= din, wptr+1 mod DEPTH, count+1.
- Drop: on wr_evt when full and no simultaneous accepted read, din is dropped and overflow <= 1. Pointers and count are unchanged.
- Read: on rd_en & ~empty, dout <= mem[rptr] at the next edge, dout_valid=1 for exactly that cycle, and rptr+1 mod DEPTH, count-1.
  - rd_en when empty is ignored: dout holds, dout_valid=0, no error flag.
  - Read latency is 1 cycle from the rd_en edge.
  - rd_en held high pops one entry per cycle while not empty.
- Simultaneous read and write:
  - Not full and not empty: both performed, count unchanged.
  - Full: the read frees the slot, so the write is accepted, count stays DEPTH, no overflow.
  - Empty: the read is ignored and the write is accepted (no fall-through); dout_valid=0.
- Overflow flag: clr_ovf clears it. If a drop and clr_ovf occur in the same cycle, set wins (overflow=1).
- Window:
  - On every wr_evt, including dropped writes, window <= {window[(WIN-1)*DATA_W-1:0], din}.
  - Independent of FIFO reads; never cleared except by reset.
  - When WIN=1, window simply takes din.
- Flags: empty, full and count are registered state, valid in the cycle after the updating edge.
- Arithmetic: pointers are $clog2(DEPTH) bits and wrap naturally. count never exceeds DEPTH and never underflows.
- Storage: may use a plain register array; no read-during-write bypass is required beyond the rules above.

Test Plan:
- Reset with wr_in held high (EDGE_IN=1), then keep wr_in high 10 cycles -> count=0, window=0, no write. Drop wr_in, raise it with din=0xA5 -> count=1, window[7:0]=0xA5.
- EDGE_IN=1: write 0x11, 0x22, 0x33, 0x44 via rise/fall pulses -> window=24'h223344, count=4. Pop 4 times -> dout 0x11, 0x22, 0x33, 0x44, each with a single dout_valid pulse one cycle after rd_en. Then empty=1.
- Fill 16 entries 0x00..0x0F, then write 0x10 -> full=1, count=16, overflow=1, window[7:0]=0x10. Pop all 16 -> 0x00..0x0F in order. Assert clr_ovf -> overflow=0.
- Full FIFO, EDGE_IN=0, assert wr_in (din=0x77) and rd_en in the same cycle -> dout=0x00, count stays 16, overflow stays 0. The last entry popped is 0x77.
- Empty FIFO, simultaneous wr_in (din=0x5A) and rd_en -> dout_valid=0, count=1. The next rd_en returns 0x5A.
- With count=5, assert rst for 1 cycle while rd_en=1 -> dout_valid=0, count=0, empty=1, window=0, overflow=0. rd_en afterwards produces no dout_valid.
